// File: rtl/noc_link_pkg.sv
// noc_link_pkg: shared constants for the dual-rail 4-phase serial link endpoints.
package noc_link_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACK_HI = 2'b01;
    localparam logic [1:0] ACK_LO = 2'b10;
    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;
    localparam int CNT_W = 8;
endpackage

// File: rtl/noc_dr_decode.sv
// noc_dr_decode: classifies a dual-rail symbol as data (with its bit value), null or illegal.
module noc_dr_decode
    import noc_link_pkg::*;
(
    input  logic [1:0] noc_d,
    output logic       valid,
    output logic       d_bit,
    output logic       d_null,
    output logic       illegal
);
    assign valid   = noc_d == DR_ZERO || noc_d == DR_ONE;
    assign d_bit   = noc_d == DR_ONE;
    assign d_null  = noc_d == DR_NULL;
    assign illegal = noc_d == DR_ILLEGAL;
endmodule

// File: rtl/tx_intf.sv
// tx_intf: NoC-side dual-rail 4-phase responder; deserialises MSB-first and publishes word/count/toggle.
// Define TX_INTF_ERR_EN to add the sticky tx_err output (illegal symbol or overflow drop).
module tx_intf
    import noc_link_pkg::*;
#(
    parameter int NOC_WID = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               noc_req,
    input  logic [1:0]         noc_d,
    output logic               noc_ack,
    output logic [NOC_WID-1:0] tx,
    output logic [CNT_W-1:0]   tx_bits,
    output logic               tx_toggle
`ifdef TX_INTF_ERR_EN
    ,
    output logic               tx_err
`endif
);
    localparam logic [NOC_WID-1:0] MSB = {1'b1, {(NOC_WID-1){1'b0}}};

    logic [1:0]         state;
    logic [NOC_WID-1:0] sr;
    logic [CNT_W-1:0]   cnt;
    logic               valid, d_bit, d_null, illegal;
    logic [NOC_WID-1:0] pos;
    logic               drop;

    noc_dr_decode u_dec (
        .noc_d   (noc_d),
        .valid   (valid),
        .d_bit   (d_bit),
        .d_null  (d_null),
        .illegal (illegal)
    );

    // one-hot write position; shifts to zero once the word is full, so extra bits fall away
    assign pos     = MSB >> cnt;
    assign drop    = cnt >= CNT_W'(NOC_WID);
    assign noc_ack = state == ACK_HI;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            tx        <= '0;
            tx_bits   <= '0;
            tx_toggle <= 1'b0;
        end else begin
            case (state)
                IDLE: if (noc_req) begin
                    sr    <= '0;
                    cnt   <= '0;
                    state <= ACK_HI;
                end
                ACK_HI: if (valid) begin
                    sr    <= d_bit ? sr | pos : sr & ~pos;
                    cnt   <= cnt + CNT_W'(cnt != '1);
                    state <= ACK_LO;
                end else if (!noc_req && (d_null || illegal)) begin
                    tx        <= sr;
                    tx_bits   <= cnt;
                    tx_toggle <= ~tx_toggle;
                    state     <= IDLE;
                end
                ACK_LO: if (d_null) state <= ACK_HI;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TX_INTF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_err <= 1'b0;
        else if (state == IDLE && noc_req)
            tx_err <= 1'b0;
        else if (state != IDLE && (illegal || (noc_ack && valid && drop)))
            tx_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_tx_intf.sv
// tb_tx_intf: table-driven 4-phase sender with a publish scoreboard for tx_intf.
// Builds with or without TX_INTF_ERR_EN; tx_err is checked only when it exists.
module tb_tx_intf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        noc_req = 1'b0;
    logic [1:0]  noc_d = 2'b00;
    logic        noc_ack;
    logic [15:0] tx;
    logic [7:0]  tx_bits;
    logic        tx_toggle;
    logic        tx_err;

    int checks = 0;
    int errors = 0;
    int pubs = 0;

    typedef struct {
        logic [15:0] tx;
        logic [7:0]  bits;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          ill;
        logic [15:0] etx;
        int          ebits;
        logic        eerr;
    } vec_t;
    vec_t vt[8];

    tx_intf #(.NOC_WID(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .noc_req   (noc_req),
        .noc_d     (noc_d),
        .noc_ack   (noc_ack),
        .tx        (tx),
        .tx_bits   (tx_bits),
        .tx_toggle (tx_toggle)
`ifdef TX_INTF_ERR_EN
        ,
        .tx_err    (tx_err)
`endif
    );

`ifndef TX_INTF_ERR_EN
    assign tx_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // publish monitor: every toggle edge must match the oldest expected word
    logic        prev_tog;
    logic [15:0] prev_tx;
    logic [7:0]  prev_bits;
    always @(negedge clk) begin
        if (rst) begin
            prev_tog  = tx_toggle;
            prev_tx   = tx;
            prev_bits = tx_bits;
        end else if (tx_toggle !== prev_tog) begin
            pubs++;
            if (sb.size() == 0) begin
                chk(1, 0, "unexpected_publish");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(tx, e.tx, "pub_tx");
                chk(tx_bits, e.bits, "pub_bits");
`ifdef TX_INTF_ERR_EN
                chk(tx_err, e.err, "pub_err");
`endif
            end
            prev_tog  = tx_toggle;
            prev_tx   = tx;
            prev_bits = tx_bits;
        end else begin
            chk({tx, tx_bits}, {prev_tx, prev_bits}, "stable_between_publish");
        end
    end

    task automatic send(input logic [31:0] bits, input int n, input int ill,
                        input logic [15:0] etx, input int ebits, input logic eerr);
        logic b;
        int idx;
        sb.push_back('{etx, 8'(ebits), eerr});
        noc_req = 1'b1;
        @(negedge clk);
        chk(noc_ack, 1, "ack_rise_on_req");
`ifdef TX_INTF_ERR_EN
        chk(tx_err, 0, "err_clear_at_start");
`endif
        for (int k = 0; k < ill; k++) begin
            noc_d = 2'b11;
            @(negedge clk);
            chk(noc_ack, 1, "ack_hold_on_illegal");
        end
        for (int i = 0; i < n; i++) begin
            idx = n - 1 - i;
            b = idx < 32 ? bits[idx] : 1'b1;
            noc_d = b ? 2'b10 : 2'b01;
            @(negedge clk);
            chk(noc_ack, 0, "ack_fall_on_data");
            noc_d = 2'b00;
            @(negedge clk);
            chk(noc_ack, 1, "ack_rise_on_null");
        end
        noc_req = 1'b0;
        @(negedge clk);
        chk(noc_ack, 0, "ack_low_after_req_drop");
        #1;
        chk(sb.size(), 0, "publish_pending");
    endtask

    initial begin
        vt[0] = '{32'hCA,       8,   0, 16'hCA00, 8,   1'b0};
        vt[1] = '{32'hA5C3,     16,  0, 16'hA5C3, 16,  1'b0};
        vt[2] = '{32'hFF,       8,   0, 16'hFF00, 8,   1'b0};
        vt[3] = '{32'hFFFFF,    20,  0, 16'hFFFF, 20,  1'b1};
        vt[4] = '{32'h1,        1,   3, 16'h8000, 1,   1'b1};
        vt[5] = '{32'h5,        3,   0, 16'hA000, 3,   1'b0};
        vt[6] = '{32'h10001,    17,  0, 16'h8000, 17,  1'b1};
        vt[7] = '{32'hFFFFFFFF, 260, 0, 16'hFFFF, 255, 1'b1};

        repeat (2) @(negedge clk);
        chk(noc_ack, 0, "reset_ack");
        chk(tx, 0, "reset_tx");
        chk(tx_bits, 0, "reset_bits");
        chk(tx_toggle, 0, "reset_toggle");
`ifdef TX_INTF_ERR_EN
        chk(tx_err, 0, "reset_err");
`endif
        rst = 1'b0;
        @(negedge clk);
        chk(noc_ack, 0, "idle_ack");

        for (int v = 0; v < 8; v++) begin
            send(vt[v].bits, vt[v].n, vt[v].ill, vt[v].etx, vt[v].ebits, vt[v].eerr);
            if (v == 1) chk(tx_toggle, 0, "toggle_back_to_back");
        end

        // zero-bit message: req held 5 cycles with no data
        sb.push_back('{16'h0000, 8'd0, 1'b0});
        noc_req = 1'b1;
        @(negedge clk);
        chk(noc_ack, 1, "zero_ack_rise");
        repeat (4) begin
            @(negedge clk);
            chk(noc_ack, 1, "zero_ack_hold");
        end
        noc_req = 1'b0;
        @(negedge clk);
        chk(noc_ack, 0, "zero_ack_fall");
        #1 chk(sb.size(), 0, "zero_publish");

        // data with req low is accepted as a bit; publish follows on the next ACK_HI cycle
        sb.push_back('{16'h8000, 8'd1, 1'b0});
        @(negedge clk);
        noc_req = 1'b1;
        @(negedge clk);
        noc_req = 1'b0;
        noc_d = 2'b10;
        @(negedge clk);
        chk(noc_ack, 0, "late_bit_ack_low");
        noc_d = 2'b00;
        @(negedge clk);
        chk(noc_ack, 1, "late_bit_ack_high");
        @(negedge clk);
        chk(noc_ack, 0, "late_bit_publish");
        #1 chk(sb.size(), 0, "late_bit_pending");

        // illegal symbol while waiting for null keeps ack low
        sb.push_back('{16'h0000, 8'd1, 1'b1});
        @(negedge clk);
        noc_req = 1'b1;
        @(negedge clk);
        noc_d = 2'b01;
        @(negedge clk);
        chk(noc_ack, 0, "acklo_data");
        noc_d = 2'b11;
        repeat (2) begin
            @(negedge clk);
            chk(noc_ack, 0, "acklo_illegal_hold");
        end
        noc_d = 2'b00;
        @(negedge clk);
        chk(noc_ack, 1, "acklo_null");
        noc_req = 1'b0;
        @(negedge clk);
        #1 chk(sb.size(), 0, "acklo_pending");

        // async reset after 5 bits abandons the message
        @(negedge clk);
        noc_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            noc_d = 2'b10;
            @(negedge clk);
            noc_d = 2'b00;
            @(negedge clk);
        end
        chk(noc_ack, 1, "pre_reset_ack");
        rst = 1'b1;
        #1;
        chk(noc_ack, 0, "async_reset_ack");
        chk(tx, 0, "async_reset_tx");
        chk(tx_bits, 0, "async_reset_bits");
        chk(tx_toggle, 0, "async_reset_toggle");
        noc_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(noc_ack, 0, "post_reset_idle");
        begin
            int p0;
            p0 = pubs;
            send(32'h9, 4, 0, 16'h9000, 4, 1'b0);
            chk(pubs - p0, 1, "single_publish_after_reset");
            chk(tx_toggle, 1, "toggle_after_reset_msg");
        end

        repeat (3) @(negedge clk);
        chk(sb.size(), 0, "scoreboard_drained");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tx_intf.md
Name: tx_intf

Overview:
- NoC-side responder for the dual-rail 4-phase serial link.
- Accepts a bit stream on `noc_req` / `noc_d` / `noc_ack`, deserialises it MSB-first into an `NOC_WID`-bit word, and publishes the word to the host with a bit count and a toggle strobe.
- Sits at the far end of the link from the host-side serialiser. It reproduces that block's `rx` / `rx_bits` / `rx_toggle` contract as `tx` / `tx_bits` / `tx_toggle`.

Parameters:
- `NOC_WID`, 16, width of the published word and the internal shift register (2..255).

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `noc_req` input 1: message request from the sender; high for the whole message.
- `noc_d` input 2: dual-rail data. 00 = null, 01 = bit 0, 10 = bit 1, 11 = illegal.
- `noc_ack` output 1: handshake acknowledge, registered.
- `tx` output `NOC_WID`: last completed message, left-aligned.
- `tx_bits` output 8: bit count of the last completed message, saturating.
- `tx_toggle` output 1: inverts once per completed message.

Behaviour:
- Reset (async, any state): state=IDLE, `noc_ack`=0, `tx`=0, `tx_bits`=0, `tx_toggle`=0, shift register=0, bit counter=0. Reset mid-message abandons it; nothing is published.
- `noc_ack` = (state == ACK_HI), decoded from the state register only; no combinational path from inputs.
- States:
  - IDLE: if `noc_req`, clear shift register and counter, go to ACK_HI (`noc_ack` rises 1 cycle after `req` is seen).
  - ACK_HI: waiting for data.
    - If `noc_d` is 01 or 10: write the bit into `sr[NOC_WID-1-cnt]` when cnt<`NOC_WID`, else drop it. Then cnt <= sat(cnt+1), go to ACK_LO.
    - Else if `~noc_req`: publish (`tx`<=sr, `tx_bits`<=cnt, `tx_toggle`<=~`tx_toggle`, all in the same edge), go to IDLE.
    - Else stay.
  - ACK_LO (ack low): if `noc_d`==00, go to ACK_HI; else stay.
- Priority in ACK_HI: valid data beats `req` low. Valid data with `req` low is accepted as a bit; publishing happens on a later ACK_HI cycle.
- Illegal 11 in ACK_HI: ignored, no bit captured, state holds. In ACK_LO, 11 is not null, so the block keeps waiting.
- Zero-bit message (`req` up/down with no data): publishes `tx`=0, `tx_bits`=0, toggle flips.
- Overflow: bits beyond `NOC_WID` are dropped. `tx_bits` reports the received count, saturating at 255.
- `tx` / `tx_bits` change only at publish; host sampling on toggle sees a stable word.
- Back-to-back messages: a new `req` in IDLE the cycle after publish is accepted. The host has no backpressure; an unread word is overwritten.
- Per-bit latency: data seen -> ack low 1 cycle; null seen -> ack high 1 cycle.

Optional Feature:
- Macro `TX_INTF_ERR_EN`.
- When defined, adds output `tx_err` (1 bit, reset 0), set sticky on either condition:
  - illegal 11 sampled in ACK_HI or ACK_LO;
  - a bit dropped for overflow.
- `tx_err` clears only at the start of the next message (IDLE->ACK_HI) or on reset. It is valid alongside `tx_toggle` and is published in the same edge.
- When undefined: no port; 11 and overflow are silently handled as described above.

Decomposition:
- Shared package `noc_link_pkg`:
  - state encoding localparams IDLE=2'b00, ACK_HI=2'b01, ACK_LO=2'b10;
  - dual-rail code constants DR_NULL=2'b00, DR_ZERO=2'b01, DR_ONE=2'b10, DR_ILLEGAL=2'b11;
  - bit-count width constant 8.
- One natural sub-module: `noc_dr_decode`, combinational. Input is `noc_d`; outputs are `valid`, `bit`, `null`, `illegal`. It is reused by any future link endpoint.

Test Plan:
- 8-bit message 1,1,0,0,1,0,1,0 with 4-phase sender model -> `tx`=16'hCA00, `tx_bits`=8, `tx_toggle` 0->1 exactly once, `noc_ack` low in IDLE after `req` drops.
- 16-bit message 16'hA5C3 MSB-first, then immediately an 8-bit 8'hFF -> first publish `tx`=16'hA5C3 `tx_bits`=16; second `tx`=16'hFF00 `tx_bits`=8; toggle 0->1->0.
- Zero-bit message (`req` high 5 cycles, no data) -> `tx`=0, `tx_bits`=0, toggle flips; `noc_ack` high 1 cycle after `req`, low 1 cycle after `req` drop.
- 20-bit message of all ones -> `tx`=16'hFFFF, `tx_bits`=20; with `TX_INTF_ERR_EN`, `tx_err`=1 at publish, cleared at next message start.
- `noc_d`=11 for 3 cycles in ACK_HI, then legal bit 1, 1-bit message -> `noc_ack` stays high during 11, `tx`=16'h8000, `tx_bits`=1; `tx_err`=1 when macro defined.
- Assert `rst` mid-message after 5 bits, release, send 4-bit message 1,0,0,1 -> `noc_ack`=0 immediately on reset, no publish from the aborted message, then `tx`=16'h9000, `tx_bits`=4, single toggle.
